tx_fifo_arbiter: RTL

TX_FIFO_ARBITER -- requirements
Module: tx_fifo_arbiter

---
 rtl/tx_fifo_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: round-robin arbiter between a first-word-fall-through
// echo FIFO and a packetised message source, both feeding one TX FIFO.
// Echo ownership is limited to BURST_MAX bytes per grant. A message packet,
// once granted, owns the TX FIFO until its last byte is accepted.
module tx_fifo_arbiter #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_fifo_dout,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd_en,
  input  logic        msg_valid,
  input  logic [7:0]  msg_data,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic [7:0]  tx_fifo_din,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_wr_en,
  output logic [1:0]  grant,
  output logic [15:0] tx_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ECHO = 2'b01,
    MSG  = 2'b10
  } state_t;

  // Counter value seen during the final byte of an echo burst.
  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_t      state_r;
  logic        last_msg_r;    // 1: message source held the most recent grant
  logic [7:0]  burst_cnt_r;
  logic [15:0] tx_count_r;
  logic        echo_xfer_s;
  logic        msg_xfer_s;

  // Per-cycle transfer qualifiers: owner has data and the TX FIFO has room.
  always_comb begin
    echo_xfer_s = 1'b0;
    msg_xfer_s  = 1'b0;
    case (state_r)
      ECHO: echo_xfer_s = !rx_fifo_empty && !tx_fifo_full;
      MSG:  msg_xfer_s  = msg_valid && !tx_fifo_full;
      default: begin
        echo_xfer_s = 1'b0;
        msg_xfer_s  = 1'b0;
      end
    endcase
  end

  // Output steering: data bus is zero whenever no write is strobed.
  always_comb begin
    rx_fifo_rd_en = echo_xfer_s;
    msg_ready     = msg_xfer_s;
    tx_fifo_wr_en = echo_xfer_s | msg_xfer_s;
    if (echo_xfer_s) begin
      tx_fifo_din = rx_fifo_dout;
    end else if (msg_xfer_s) begin
      tx_fifo_din = msg_data;
    end else begin
      tx_fifo_din = 8'h00;
    end
  end

  assign grant    = state_r;
  assign tx_count = tx_count_r;

  // Ownership FSM with round-robin tie-break and echo burst limiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      last_msg_r  <= 1'b1;
      burst_cnt_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          burst_cnt_r <= 8'h00;
          if (!rx_fifo_empty && (!msg_valid || last_msg_r)) begin
            state_r    <= ECHO;
            last_msg_r <= 1'b0;
          end else if (msg_valid) begin
            state_r    <= MSG;
            last_msg_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ECHO: begin
          if (rx_fifo_empty) begin
            state_r <= IDLE;
          end else if (echo_xfer_s) begin
            burst_cnt_r <= burst_cnt_r + 8'd1;
            if (burst_cnt_r == BURST_LAST) begin
              state_r <= IDLE;
            end else begin
              state_r <= ECHO;
            end
          end else begin
            state_r <= ECHO;
          end
        end
        MSG: begin
          if (msg_xfer_s && msg_last) begin
            state_r <= IDLE;
          end else begin
            state_r <= MSG;
          end
        end
        default: begin
          state_r     <= IDLE;
          burst_cnt_r <= 8'h00;
        end
      endcase
    end
  end

  // Running count of bytes written to the TX FIFO, wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count_r <= 16'h0000;
    end else if (tx_fifo_wr_en) begin
      tx_count_r <= tx_count_r + 16'd1;
    end else begin
      tx_count_r <= tx_count_r;
    end
  end

endmodule
